// File: rtl/zero_stuff_interp.sv
// Zero-stuffing / zero-order-hold interpolator: one input sample becomes a burst
// of L output beats, with valid/ready flow control on both sides.
module zero_stuff_interp #(
  parameter int unsigned Win   = 16,
  parameter int unsigned L_MAX = 16,
  parameter int unsigned LW    = 5,
  parameter int unsigned CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [Win-1:0] data_in,
  input  logic                  val_in,
  output logic                  rdy_in,
  input  logic [LW-1:0]         l_factor,
  input  logic                  mode,
  output logic signed [Win-1:0] data_out,
  output logic                  val_out,
  input  logic                  out_rdy,
  output logic [LW-1:0]         phase_out,
  output logic [CNT_W-1:0]      sample_count
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                r_state;
  logic signed [Win-1:0] r_sample;
  logic                  r_mode;
  logic [LW-1:0]         r_l_lat;
  logic signed [Win-1:0] r_data;
  logic                  r_val;
  logic [LW-1:0]         r_phase;
  logic [CNT_W-1:0]      r_count;

  logic          w_last;
  logic          w_accept;
  logic [LW-1:0] w_l_clamp;

  assign w_last   = (r_phase == (r_l_lat - LW'(1)));
  assign rdy_in   = !rst && ((r_state == IDLE) || ((r_state == EMIT) && w_last && out_rdy));
  assign w_accept = val_in && rdy_in;

  // Factor 0 degenerates to pass-through; anything beyond L_MAX saturates.
  always_comb begin
    w_l_clamp = l_factor;
    if (l_factor == '0)
      w_l_clamp = LW'(1);
    else if (l_factor > LW'(L_MAX))
      w_l_clamp = LW'(L_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sample <= '0;
      r_mode   <= 1'b0;
      r_l_lat  <= LW'(1);
      r_data   <= '0;
      r_val    <= 1'b0;
      r_phase  <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      // Covers both idle start and back-to-back reload on the last beat.
      r_state  <= EMIT;
      r_sample <= data_in;
      r_mode   <= mode;
      r_l_lat  <= w_l_clamp;
      r_data   <= data_in;
      r_val    <= 1'b1;
      r_phase  <= '0;
      r_count  <= r_count + CNT_W'(1);
    end else if ((r_state == EMIT) && out_rdy) begin
      if (!w_last) begin
        r_phase <= r_phase + LW'(1);
        r_data  <= r_mode ? r_sample : '0;
      end else begin
        r_state <= IDLE;
        r_val   <= 1'b0;
        r_data  <= '0;
        r_phase <= '0;
      end
    end
  end

  assign data_out     = r_data;
  assign val_out      = r_val;
  assign phase_out    = r_phase;
  assign sample_count = r_count;

endmodule

// File: tb/tb_zero_stuff_interp.sv
// Bench for zero_stuff_interp: queue-of-beats reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_zero_stuff_interp;

  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic signed [15:0] d;
    logic [4:0]         ph;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               val_in = 1'b0;
  logic               rdy_in;
  logic [4:0]         l_factor = 5'd1;
  logic               mode = 1'b0;
  logic signed [15:0] data_out;
  logic               val_out;
  logic               out_rdy = 1'b1;
  logic [4:0]         phase_out;
  logic [CNT_W-1:0]   sample_count;

  zero_stuff_interp #(.Win(16), .L_MAX(16), .LW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .val_in(val_in), .rdy_in(rdy_in),
    .l_factor(l_factor), .mode(mode), .data_out(data_out), .val_out(val_out),
    .out_rdy(out_rdy), .phase_out(phase_out), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t q[$];
  int    cnt = 0;
  bit    mdl_live = 1'b0;

  logic               obs_val;
  logic signed [15:0] obs_data;
  logic [4:0]         obs_ph;
  logic [CNT_W-1:0]   obs_cnt;
  logic               obs_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // One clock: check registered outputs vs model, apply inputs, check rdy_in, advance model.
  task automatic step(input logic r, input logic v, input logic signed [15:0] d,
                      input logic [4:0] lf, input logic m, input logic ordy);
    logic signed [15:0] ed;
    logic [4:0]         eph;
    logic               erdy;
    beat_t              b;
    int                 len;
    @(negedge clk);
    if (mdl_live) begin
      ed  = (q.size() != 0) ? q[0].d  : 16'sd0;
      eph = (q.size() != 0) ? q[0].ph : 5'd0;
      chk("val_out", 32'(val_out), 32'(q.size() != 0));
      chk("data_out", data_out, ed);
      chk("phase_out", 32'(phase_out), 32'(eph));
      chk("sample_count", 32'(sample_count), 32'(cnt));
    end
    obs_val = val_out; obs_data = data_out; obs_ph = phase_out; obs_cnt = sample_count;
    rst = r; val_in = v; data_in = d; l_factor = lf; mode = m; out_rdy = ordy;
    #1;
    erdy = !r && ((q.size() == 0) || ((q.size() == 1) && ordy));
    chk("rdy_in", 32'(rdy_in), 32'(erdy));
    obs_rdy = rdy_in;
    if (r) begin
      q.delete();
      cnt = 0;
      mdl_live = 1'b1;
    end else begin
      if ((q.size() != 0) && ordy) void'(q.pop_front());
      if (v && erdy) begin
        len = (lf == 0) ? 1 : ((lf > 16) ? 16 : int'(lf));
        for (int k = 0; k < len; k++) begin
          b.d  = (m || k == 0) ? d : 16'sd0;
          b.ph = 5'(k);
          q.push_back(b);
        end
        cnt = (cnt + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'sd0, 5'd1, 1'b0, 1'b1);
  endtask

  task automatic lit(input string nm, input logic v, input int d, input int ph);
    chk({nm, "_val"}, 32'(obs_val), 32'(v));
    chk({nm, "_data"}, obs_data, d);
    chk({nm, "_phase"}, 32'(obs_ph), ph);
  endtask

  initial begin
    int exp_d[6];
    int exp_p[6];
    int beats;
    int maxph;

    // Reset then idle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'sd0, 5'd1, 1'b0, 1'b1);
    idle(1);
    lit("reset", 1'b0, 0, 0);
    chk("reset_count", 32'(obs_cnt), 0);
    chk("reset_rdy", 32'(obs_rdy), 1);

    // Zero-stuff L=4 with back-to-back second sample
    step(1'b0, 1'b1, 16'sd1000, 5'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 5'd4, 1'b0, 1'b1);
    lit("zs_p0", 1'b1, 1000, 0); chk("zs_p0_rdy", 32'(obs_rdy), 0);
    step(1'b0, 1'b0, 16'sd0, 5'd4, 1'b0, 1'b1);
    lit("zs_p1", 1'b1, 0, 1);
    step(1'b0, 1'b0, 16'sd0, 5'd4, 1'b0, 1'b1);
    lit("zs_p2", 1'b1, 0, 2); chk("zs_p2_rdy", 32'(obs_rdy), 0);
    step(1'b0, 1'b1, -16'sd1000, 5'd4, 1'b0, 1'b1);
    lit("zs_p3", 1'b1, 0, 3); chk("zs_p3_rdy", 32'(obs_rdy), 1);
    step(1'b0, 1'b0, 16'sd0, 5'd4, 1'b0, 1'b1);
    lit("zs_next", 1'b1, -1000, 0); chk("zs_count", 32'(obs_cnt), 2);
    idle(4);

    // Hold mode with output stall
    step(1'b0, 1'b1, 16'sh7FFF, 5'd3, 1'b1, 1'b1);
    exp_p[0] = 0; exp_p[1] = 1; exp_p[2] = 1; exp_p[3] = 1; exp_p[4] = 2;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'sd0, 5'd3, 1'b1, (i == 1 || i == 2) ? 1'b0 : 1'b1);
      lit("hold", 1'b1, 32'h7FFF, exp_p[i]);
    end
    step(1'b0, 1'b0, 16'sd0, 5'd3, 1'b1, 1'b1);
    chk("hold_end_val", 32'(obs_val), 0);

    // Clamp: factor 0 gives one beat, factor 20 gives 16
    step(1'b0, 1'b1, 16'sd42, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 5'd0, 1'b0, 1'b1);
    lit("l0", 1'b1, 42, 0); chk("l0_rdy", 32'(obs_rdy), 1);
    step(1'b0, 1'b0, 16'sd0, 5'd0, 1'b0, 1'b1);
    chk("l0_end_val", 32'(obs_val), 0);
    step(1'b0, 1'b1, 16'sd9, 5'd20, 1'b0, 1'b1);
    beats = 0; maxph = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 16'sd0, 5'd20, 1'b0, 1'b1);
      if (obs_val) begin
        beats++;
        if (int'(obs_ph) > maxph) maxph = int'(obs_ph);
      end
    end
    chk("l20_beats", beats, 16);
    chk("l20_maxphase", maxph, 15);

    // Mid-burst factor/mode change affects only the next burst
    exp_d[0] = 500; exp_d[1] = 0; exp_d[2] = 0; exp_d[3] = 0; exp_d[4] = 77; exp_d[5] = 77;
    exp_p[0] = 0; exp_p[1] = 1; exp_p[2] = 2; exp_p[3] = 3; exp_p[4] = 0; exp_p[5] = 1;
    step(1'b0, 1'b1, 16'sd500, 5'd4, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 4) ? 1'b1 : 1'b0, 16'sd77, 5'd2, 1'b1, 1'b1);
      lit("midchg", 1'b1, exp_d[i], exp_p[i]);
    end
    step(1'b0, 1'b0, 16'sd0, 5'd2, 1'b1, 1'b1);
    chk("midchg_end_val", 32'(obs_val), 0);

    // Counter wrap with L=1 at full throughput
    step(1'b1, 1'b0, 16'sd0, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 16'(i * 3 - 20), 5'd1, 1'b0, 1'b1);
      chk("l1_rdy", 32'(obs_rdy), 1);
    end
    step(1'b0, 1'b0, 16'sd0, 5'd1, 1'b0, 1'b1);
    chk("wrap_count", 32'(obs_cnt), 1);
    idle(1);

    // Reset in the middle of an L=8 burst
    step(1'b0, 1'b1, 16'sd123, 5'd8, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 5'd8, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 5'd8, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'sd0, 5'd8, 1'b1, 1'b1);
    lit("prerst", 1'b1, 123, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 16'sd0, 5'd8, 1'b1, 1'b1);
      lit("postrst", 1'b0, 0, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 1)),
           16'($urandom),
           5'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zero_stuff_interp.md
Name: zero_stuff_interp

Overview:
- Parametrised successor to the single-sample valid/zero-insert register stage.
- Accepts one signed sample per input handshake and emits a burst of L output samples, where L is programmable at run time.
- Burst content: the sample followed by L-1 zeros (zero-stuffing) or L copies of the sample (zero-order hold), selected by mode.
- Sits between a sample source and an interpolation FIR, with valid/ready flow control on both sides and an accepted-sample counter.

Parameters:
- Win, 16, sample width in bits (signed).
- L_MAX, 16, maximum interpolation factor (≥2).
- LW, 5, width of l_factor input; must satisfy 2^LW > L_MAX.
- CNT_W, 12, width of accepted-sample counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  Win  signed input sample.
- val_in  input  1  input sample valid.
- rdy_in  output  1  block can accept a sample this cycle (combinational).
- l_factor  input  LW  interpolation factor L, sampled at acceptance.
- mode  input  1  0 = zero-stuff, 1 = hold; sampled at acceptance.
- data_out  output  Win  signed output sample (registered).
- val_out  output  1  data_out valid (registered).
- out_rdy  input  1  downstream ready.
- phase_out  output  LW  index of current output within burst, 0..L-1 (registered).
- sample_count  output  CNT_W  number of accepted input samples, modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at rising edge):
  - data_out=0, val_out=0, phase_out=0, sample_count=0, state=IDLE.
  - rdy_in is forced 0 while rst=1.
  - Reset mid-burst abandons the burst; the remaining phases are never emitted.
- States:
  - IDLE: val_out=0, data_out=0.
  - EMIT: val_out=1, burst in progress.
- Acceptance:
  - Handshake: val_in & rdy_in at a rising edge.
  - rdy_in = !rst & (state==IDLE | (state==EMIT & last & out_rdy)), where last = (phase_out == L_lat-1).
- On acceptance:
  - Latch data_in into sample register.
  - Latch mode.
  - Latch L_lat = clamp(l_factor): 0→1, >L_MAX→L_MAX, otherwise l_factor.
  - sample_count += 1, wrapping from 2^CNT_W-1 to 0.
  - Next state = EMIT, phase_out=0, data_out=data_in, val_out=1.
- Latency: a sample accepted at edge N appears on data_out at phase 0 in the cycle following edge N.
- Output advance:
  - A beat is transferred when val_out & out_rdy.
  - If not last: phase_out+1; data_out = 0 (mode 0) or sample (mode 1).
  - If last and a new sample is accepted in the same cycle: load new phase 0 (back-to-back, no bubble).
  - If last and no new sample is accepted: go to IDLE, val_out=0, data_out=0, phase_out=0.
- Stall: while val_out=1 and out_rdy=0, data_out, phase_out and val_out hold unchanged.
- L_lat=1: every accepted sample yields exactly one beat; with out_rdy=1 and val_in=1 continuously, throughput is one sample per cycle.
- l_factor and mode changes during a burst have no effect until the next acceptance.
- val_in while rdy_in=0: the sample is not consumed and the counter is unchanged; the source must hold it.
- Arithmetic: no scaling applied; data passes bit-exact. Zeros are all-zero Win-bit words.

Test Plan:
- Reset then idle: rst high 3 cycles, then low with val_in=0 → val_out=0, data_out=0, sample_count=0, rdy_in=1 after release.
- Zero-stuff L=4, mode=0, out_rdy=1:
  - Stimulus: accept 16'sd1000.
  - Response: data_out sequence 1000,0,0,0 with phase 0..3 on consecutive cycles; rdy_in=1 only in the phase-3 cycle.
  - Continuation: next sample -1000 presented then gives -1000 immediately after with no bubble; sample_count=2.
- Hold mode with stall: L=3, mode=1, sample 16'sh7FFF, out_rdy pattern 1,0,0,1,1 → outputs 7FFF×3, and phase holds at 1 during the two stall cycles.
- Clamping: l_factor=0 gives a single beat per sample; l_factor=20 with L_MAX=16 gives exactly 16 beats (phase 0..15).
- Mid-burst changes:
  - Stimulus: change l_factor 4→2 and mode 0→1 during a burst.
  - Response: current burst stays 4 zero-stuffed beats; next burst is 2 held beats.
- Counter wrap and reset:
  - Counter: with CNT_W=4 and L=1, accept 17 samples → sample_count=1.
  - Reset mid-burst: rst at phase 2 of an L=8 burst → val_out=0 on the next cycle and no further beats.
